gcd_share_ctrl: RTL and testbench

//  Sequencer and round-robin arbiter that shares one subtractive GCD datapath (A/B regs,

---
 rtl/gcd_share_ctrl.sv | 179 +++++++++++++++++
 tb/tb_gcd_share_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_share_ctrl.sv
// gcd_share_ctrl
//   Sequencer plus round-robin arbiter that shares one external subtractive
//   GCD datapath (A/B registers, comparator, subtractor, input mux) among
//   N_REQ requesters. One request is granted at a time. Both operands are
//   loaded, the larger-minus-smaller loop runs until the comparator reports
//   equality, and the result is returned with a one-cycle ack to the granted
//   requester.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req           per-requester service request, held until its ack
//   op_a, op_b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   ack           one-hot single-cycle completion pulse
//   result        registered GCD of the most recently served request
//   busy          high whenever the sequencer is not idle
//   gt, lt, eq    datapath comparator flags (A>B, A<B, A==B)
//   dp_aout       datapath A register value
//   lda, ldb      datapath A / B register load enables
//   sel1, sel2    subtractor operand order: 01 -> A-B, 10 -> B-A
//   sel_in        datapath input mux: 1 = dp_data_in, 0 = subtractor
//   dp_data_in    operand presented to the datapath during the load states
module gcd_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  input  logic                   gt,
  input  logic                   lt,
  input  logic                   eq,
  input  logic [WIDTH-1:0]       dp_aout,
  output logic                   lda,
  output logic                   ldb,
  output logic                   sel1,
  output logic                   sel2,
  output logic                   sel_in,
  output logic [WIDTH-1:0]       dp_data_in
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CMP,
    S_SUB_A,
    S_SUB_B,
    S_DONE,
    S_ZDONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] gnt, gnt_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [WIDTH-1:0] result_nxt;

  logic [IDX_W-1:0] pick;
  logic             found;
  logic [WIDTH-1:0] pick_a, pick_b;
  logic [WIDTH-1:0] gnt_a, gnt_b;

  // Round-robin search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    int j;
    pick  = ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        pick  = IDX_W'(j);
        found = 1'b1;
      end
    end
  end

  assign pick_a = op_a[int'(pick)*WIDTH +: WIDTH];
  assign pick_b = op_b[int'(pick)*WIDTH +: WIDTH];
  assign gnt_a  = op_a[int'(gnt)*WIDTH +: WIDTH];
  assign gnt_b  = op_b[int'(gnt)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt    <= '0;
      ptr    <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      ptr    <= ptr_nxt;
      result <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    ptr_nxt    = ptr;
    result_nxt = result;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          gnt_nxt = pick;
          // A zero operand makes the GCD the other operand; skip the datapath.
          if (pick_a == '0 || pick_b == '0) begin
            state_nxt  = S_ZDONE;
            result_nxt = pick_a | pick_b;
          end else begin
            state_nxt = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_CMP;
      S_CMP: begin
        // Only a clean single-flag gt or lt keeps looping; eq and any
        // malformed flag combination finish with the current A value.
        if (gt && !lt && !eq) begin
          state_nxt = S_SUB_A;
        end else if (lt && !gt && !eq) begin
          state_nxt = S_SUB_B;
        end else begin
          state_nxt  = S_DONE;
          result_nxt = dp_aout;
        end
      end
      S_SUB_A: state_nxt = S_CMP;
      S_SUB_B: state_nxt = S_CMP;
      S_DONE, S_ZDONE: begin
        state_nxt = S_IDLE;
        ptr_nxt   = (int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode from state and the registered grant.
  always_comb begin
    ack        = '0;
    busy       = (state != S_IDLE);
    lda        = 1'b0;
    ldb        = 1'b0;
    sel1       = 1'b0;
    sel2       = 1'b0;
    sel_in     = 1'b0;
    dp_data_in = '0;
    unique case (state)
      S_LOAD_A: begin
        sel_in     = 1'b1;
        lda        = 1'b1;
        dp_data_in = gnt_a;
      end
      S_LOAD_B: begin
        sel_in     = 1'b1;
        ldb        = 1'b1;
        dp_data_in = gnt_b;
      end
      S_SUB_A: begin
        sel2 = 1'b1;
        lda  = 1'b1;
      end
      S_SUB_B: begin
        sel1 = 1'b1;
        ldb  = 1'b1;
      end
      S_DONE, S_ZDONE: ack[gnt] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_share_ctrl.sv
`timescale 1ns/1ps
module tb_gcd_share_ctrl;
  localparam int N_REQ = 4;
  localparam int WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] op_a = '0;
  logic [N_REQ*WIDTH-1:0] op_b = '0;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       result;
  logic                   busy;
  logic                   gt, lt, eq;
  logic [WIDTH-1:0]       dp_aout;
  logic                   lda, ldb, sel1, sel2, sel_in;
  logic [WIDTH-1:0]       dp_data_in;

  always #5 clk = ~clk;

  gcd_share_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .result(result), .busy(busy),
    .gt(gt), .lt(lt), .eq(eq), .dp_aout(dp_aout),
    .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .dp_data_in(dp_data_in)
  );

  // External shared datapath: A/B registers, subtractor, input mux, comparator.
  logic [WIDTH-1:0] dp_a = '0;
  logic [WIDTH-1:0] dp_b = '0;
  logic [WIDTH-1:0] sub_out, mux_out;
  always_comb sub_out = (sel1 && !sel2) ? dp_b - dp_a : dp_a - dp_b;
  always_comb mux_out = sel_in ? dp_data_in : sub_out;
  always @(posedge clk) begin
    if (lda) dp_a <= mux_out;
    if (ldb) dp_b <= mux_out;
  end
  assign gt      = dp_a > dp_b;
  assign lt      = dp_a < dp_b;
  assign eq      = dp_a == dp_b;
  assign dp_aout = dp_a;

  // Reference model
  typedef struct {
    int idx;
    int res;
    int lat;    // cycles from first busy cycle to ack cycle
    int loads;  // cycles with lda or ldb asserted during the job
  } exp_t;

  exp_t exp_q[$];

  function automatic int ref_gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int n_sub(int a, int b);
    int n;
    n = 0;
    while (a != b) begin
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
    return n;
  endfunction

  function automatic exp_t mk_exp(int i, int a, int b);
    exp_t e;
    int s;
    e.idx = i;
    if (a == 0 || b == 0) begin
      e.res   = a | b;
      e.lat   = 0;
      e.loads = 0;
    end else begin
      s       = n_sub(a, b);
      e.res   = ref_gcd(a, b);
      e.lat   = 3 + 2 * s;
      e.loads = 2 + s;
    end
    return e;
  endfunction

  // Scoreboard / monitor
  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_timeouts = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;
  logic busy_q = 1'b0;
  int   start_cyc = 0;
  int   loads = 0;

  task automatic chk(input string name, input int act, input int req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    int   st, ld, ai;
    exp_t e;
    st = start_cyc;
    ld = loads;
    if (rst_seen) begin
      chk("rst_ctrl_outputs", int'({ack, busy, lda, ldb, sel1, sel2, sel_in}), 0);
      chk("rst_dp_data_in", int'(dp_data_in), 0);
      chk("rst_result", int'(result), 0);
    end else begin
      if (busy && !busy_q) begin
        st = cyc;
        ld = 0;
      end
      if (busy && (lda || ldb)) ld = ld + 1;
      if (ack != '0) begin
        chk("ack_onehot", $countones(ack), 1);
        ai = 0;
        for (int i = N_REQ - 1; i >= 0; i--) if (ack[i]) ai = i;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", int'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_index", ai, e.idx);
          chk("result", int'(result), e.res);
          chk("latency", cyc - st, e.lat);
          chk("load_cycles", ld, e.loads);
        end
      end
    end
    if (end_req && !end_done) begin
      chk("queue_drained", exp_q.size(), 0);
      chk("timeouts", n_timeouts, 0);
      end_done <= 1'b1;
    end
    start_cyc <= st;
    loads     <= ld;
    busy_q    <= busy;
  end

  // Stimulus
  logic [WIDTH-1:0] ta  [N_REQ];
  logic [WIDTH-1:0] tbv [N_REQ];
  int               tb_ptr = 0;

  task automatic set_op(input int i, input int a, input int b);
    ta[i]  = WIDTH'(a);
    tbv[i] = WIDTH'(b);
  endtask

  // Issues all requests in mask at once and services them until every one
  // has been acked. drop_early releases req (and scrambles operands) in the
  // CMP cycle of a single job; rst_at pulses reset in that busy cycle.
  task automatic run_batch(input logic [N_REQ-1:0] mask, input bit drop_early,
                           input int rst_at);
    logic [N_REQ-1:0] pending;
    int               budget, since, last, j;
    bit               did_rst;
    last = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (tb_ptr + k) % N_REQ;
      if (mask[j]) begin
        exp_q.push_back(mk_exp(j, int'(ta[j]), int'(tbv[j])));
        last = j;
      end
    end
    if (mask != '0) tb_ptr = (last + 1) % N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i*WIDTH +: WIDTH] = ta[i];
      op_b[i*WIDTH +: WIDTH] = tbv[i];
    end
    req     = mask;
    pending = mask;
    budget  = 0;
    since   = 0;
    did_rst = 1'b0;
    while (pending != '0 && budget < 20000) begin
      @(negedge clk);
      budget++;
      rst = 1'b0;
      if (busy) since++;
      if (drop_early && busy && since == 3) begin
        req  = '0;
        op_a = {N_REQ{WIDTH'($urandom)}};
        op_b = {N_REQ{WIDTH'($urandom)}};
      end
      if (rst_at > 0 && !did_rst && busy && since == rst_at) begin
        rst     = 1'b1;
        did_rst = 1'b1;
      end
      pending = pending & ~ack;
      req     = req & ~ack;
    end
    rst = 1'b0;
    if (pending != '0) begin
      n_timeouts++;
      $display("FAIL batch_timeout: pending %b, expected 0", pending);
      req = '0;
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    tb_ptr = 0;
  endtask

  initial begin
    logic [N_REQ-1:0] m;
    for (int i = 0; i < N_REQ; i++) set_op(i, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    set_op(0, 143, 78);  run_batch(4'b0001, 1'b0, 0);
    set_op(1, 48, 48);   run_batch(4'b0010, 1'b1, 0);
    set_op(2, 0, 35);    run_batch(4'b0100, 1'b0, 0);

    pulse_reset();
    set_op(0, 12, 18); set_op(1, 7, 5); set_op(2, 100, 75); set_op(3, 9, 9);
    run_batch(4'b1111, 1'b0, 0);
    run_batch(4'b0101, 1'b0, 0);
    run_batch(4'b0010, 1'b0, 0);
    run_batch(4'b0101, 1'b0, 0);

    set_op(0, 143, 78);  run_batch(4'b0001, 1'b0, 4);
    set_op(3, 1000, 1);  run_batch(4'b1000, 1'b0, 0);
    set_op(1, 0, 0);     run_batch(4'b0010, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++)
        set_op(i, ($urandom % 8 == 0) ? 0 : $urandom_range(1, 200),
                  ($urandom % 8 == 0) ? 0 : $urandom_range(1, 200));
      run_batch(m, 1'b0, 0);
    end

    end_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
